dtw_mem_dp: RTL and testbench

Parametrised, synthesizable, single-clock dual-port word memory. It replaces the fixed 1024x32 behavioural memory model used around the DTW TOP.
- Port A serves the DTW processor with the existing active-low chip-select / WR convention.
- Port B serves host load and result checking.
- Adds byte-enable writes, a configurable read latency, defined cross-port collision behaviour, out-of-range detection, and a hardware clear sequencer.

---
 rtl/dtw_mem_dp_if.sv | 24 ++
 rtl/dtw_mem_dp.sv | 185 ++++++++++++++++++
 tb/tb_dtw_mem_dp.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dtw_mem_dp_if.sv
// Word-memory access port: active-low select, write strobe, byte enables, pulsed read valid.
// The master drives requests and the slave (the memory) returns read data.
interface dtw_mem_dp_if #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 10
);
  logic            cs_n;
  logic            wr;
  logic [AW-1:0]   addr;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] be;
  logic [DW-1:0]   rdata;
  logic            rvalid;

  modport master (
    output cs_n, wr, addr, wdata, be,
    input  rdata, rvalid
  );

  modport slave (
    input  cs_n, wr, addr, wdata, be,
    output rdata, rvalid
  );
endinterface

// File: rtl/dtw_mem_dp.sv
// Dual-port byte-writable word memory with 1/2-cycle read latency, collision/range flags
// and a one-word-per-cycle clear sequencer.
module dtw_mem_dp #(
  parameter int unsigned DW         = 32,
  parameter int unsigned AW         = 10,
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned RDW_MODE   = 0,
  parameter int unsigned CLR_ON_RST = 1
) (
  input  logic          i_clk,
  input  logic          i_nrst,
  input  logic          i_clr,
  output logic          o_busy,
  dtw_mem_dp_if.slave   port_a,
  dtw_mem_dp_if.slave   port_b,
  output logic          o_coll,
  output logic          o_err
);
  localparam int unsigned NB = DW / 8;

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   clr_addr_q, clr_addr_d;
  logic            pend_q, pend_d;
  logic            busy_q, busy_d;
  logic [DW-1:0]   mem_q [DEPTH];

  logic            open;
  logic            a_in, b_in, a_acc, b_acc, a_we, b_we, a_re, b_re, same_addr;
  logic [DW-1:0]   a_rd, b_rd;
  logic            a_rv1_q, a_rv1_d, b_rv1_q, b_rv1_d;
  logic [DW-1:0]   a_rd1_q, a_rd1_d, b_rd1_q, b_rd1_d;
  logic            err1_q, err1_d, coll_q, coll_d;

  function automatic logic [DW-1:0] merge(logic [DW-1:0] old_w, logic [DW-1:0] new_w,
                                          logic [NB-1:0] be);
    logic [DW-1:0] r;
    r = old_w;
    for (int k = 0; k < NB; k++) begin
      if (be[k]) r[8*k +: 8] = new_w[8*k +: 8];
    end
    return r;
  endfunction

  // The post-reset pending clear counts as busy so no access slips in on that edge.
  assign open      = (state_q == StIdle) && !pend_q;
  assign a_in      = {1'b0, port_a.addr} < (AW+1)'(DEPTH);
  assign b_in      = {1'b0, port_b.addr} < (AW+1)'(DEPTH);
  assign a_acc     = open && !port_a.cs_n;
  assign b_acc     = open && !port_b.cs_n;
  assign a_we      = a_acc && port_a.wr && a_in;
  assign b_we      = b_acc && port_b.wr && b_in;
  assign a_re      = a_acc && !port_a.wr;
  assign b_re      = b_acc && !port_b.wr;
  assign same_addr = (port_a.addr == port_b.addr);

  always_comb begin
    a_rd = '0;
    b_rd = '0;
    if (a_in) a_rd = mem_q[port_a.addr];
    if (b_in) b_rd = mem_q[port_b.addr];
    if (RDW_MODE != 0) begin
      if (a_in && b_we && same_addr) a_rd = merge(a_rd, port_b.wdata, port_b.be);
      if (b_in && a_we && same_addr) b_rd = merge(b_rd, port_a.wdata, port_a.be);
    end
  end

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    pend_d     = pend_q;
    busy_d     = busy_q;
    unique case (state_q)
      StIdle: begin
        if (i_clr || pend_q) begin
          state_d    = StClear;
          busy_d     = 1'b1;
          clr_addr_d = '0;
          pend_d     = 1'b0;
        end
      end
      StClear: begin
        clr_addr_d = clr_addr_q + 1'b1;
        if (clr_addr_q == AW'(DEPTH - 1)) begin
          state_d = StIdle;
          busy_d  = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    a_rv1_d = a_re;
    b_rv1_d = b_re;
    a_rd1_d = a_re ? a_rd : a_rd1_q;
    b_rd1_d = b_re ? b_rd : b_rd1_q;
    err1_d  = (a_acc && !a_in) || (b_acc && !b_in);
    coll_d  = a_we && b_we && same_addr;
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q    <= StIdle;
      clr_addr_q <= '0;
      pend_q     <= (CLR_ON_RST != 0);
      busy_q     <= 1'b0;
      a_rv1_q    <= 1'b0;
      b_rv1_q    <= 1'b0;
      a_rd1_q    <= '0;
      b_rd1_q    <= '0;
      err1_q     <= 1'b0;
      coll_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      pend_q     <= pend_d;
      busy_q     <= busy_d;
      a_rv1_q    <= a_rv1_d;
      b_rv1_q    <= b_rv1_d;
      a_rd1_q    <= a_rd1_d;
      b_rd1_q    <= b_rd1_d;
      err1_q     <= err1_d;
      coll_q     <= coll_d;
    end
  end

  // Storage has no reset; byte lanes from A are assigned last so they win on a shared address.
  always_ff @(posedge i_clk) begin
    if (state_q == StClear) begin
      mem_q[clr_addr_q] <= '0;
    end else begin
      for (int k = 0; k < NB; k++) begin
        if (b_we && port_b.be[k]) mem_q[port_b.addr][8*k +: 8] <= port_b.wdata[8*k +: 8];
        if (a_we && port_a.be[k]) mem_q[port_a.addr][8*k +: 8] <= port_a.wdata[8*k +: 8];
      end
    end
  end

  if (RD_LAT == 2) begin : g_lat2
    logic          a_rv2_q, a_rv2_d, b_rv2_q, b_rv2_d, err2_q, err2_d;
    logic [DW-1:0] a_rd2_q, a_rd2_d, b_rd2_q, b_rd2_d;

    always_comb begin
      a_rv2_d = a_rv1_q;
      b_rv2_d = b_rv1_q;
      err2_d  = err1_q;
      a_rd2_d = a_rv1_q ? a_rd1_q : a_rd2_q;
      b_rd2_d = b_rv1_q ? b_rd1_q : b_rd2_q;
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
        a_rv2_q <= 1'b0;
        b_rv2_q <= 1'b0;
        err2_q  <= 1'b0;
        a_rd2_q <= '0;
        b_rd2_q <= '0;
      end else begin
        a_rv2_q <= a_rv2_d;
        b_rv2_q <= b_rv2_d;
        err2_q  <= err2_d;
        a_rd2_q <= a_rd2_d;
        b_rd2_q <= b_rd2_d;
      end
    end

    assign port_a.rvalid = a_rv2_q;
    assign port_a.rdata  = a_rd2_q;
    assign port_b.rvalid = b_rv2_q;
    assign port_b.rdata  = b_rd2_q;
    assign o_err         = err2_q;
  end else begin : g_lat1
    assign port_a.rvalid = a_rv1_q;
    assign port_a.rdata  = a_rd1_q;
    assign port_b.rvalid = b_rv1_q;
    assign port_b.rdata  = b_rd1_q;
    assign o_err         = err1_q;
  end

  assign o_coll = coll_q;
  assign o_busy = busy_q;
endmodule

// File: tb/tb_dtw_mem_dp.sv
// Two memory configurations driven with identical traffic; a scoreboard checks read data,
// latency, flags and clear timing against a word-array model.
module tb_dtw_mem_dp;
  logic clk = 1'b0;
  logic nrst = 1'b0;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  dtw_mem_dp_if #(.DW(32), .AW(10)) a0 ();
  dtw_mem_dp_if #(.DW(32), .AW(10)) b0 ();
  dtw_mem_dp_if #(.DW(32), .AW(10)) a1 ();
  dtw_mem_dp_if #(.DW(32), .AW(10)) b1 ();
  logic busy0, busy1, coll0, coll1, err0, err1;

  dtw_mem_dp #(.DW(32), .AW(10), .DEPTH(1000), .RD_LAT(1), .RDW_MODE(0), .CLR_ON_RST(1)) u_dut0 (
    .i_clk(clk), .i_nrst(nrst), .i_clr(clr), .o_busy(busy0),
    .port_a(a0), .port_b(b0), .o_coll(coll0), .o_err(err0)
  );
  dtw_mem_dp #(.DW(32), .AW(10), .DEPTH(1024), .RD_LAT(2), .RDW_MODE(1), .CLR_ON_RST(0)) u_dut1 (
    .i_clk(clk), .i_nrst(nrst), .i_clr(clr), .o_busy(busy1),
    .port_a(a1), .port_b(b1), .o_coll(coll1), .o_err(err1)
  );

  typedef struct {
    logic [31:0] data;
    int          due;
    bit          chk;
  } exp_t;

  exp_t        qr [4][$];   // read expectations, index dut*2+port
  int          qf [4][$];   // flag due cycles: err0, err1, coll0, coll1
  logic [31:0] mdl [2][1024];
  bit          known [2];
  logic [31:0] last [4];
  bit          last_ok [4];
  int          dep [2] = '{1000, 1024};
  int          lat [2] = '{1, 2};
  int          rdw [2] = '{0, 1};
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] merge(logic [31:0] old_w, logic [31:0] new_w, logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int k = 0; k < 4; k++) if (be[k]) r[8*k +: 8] = new_w[8*k +: 8];
    return r;
  endfunction

  // One clock of traffic on both ports; act[d] marks which memories are expected to accept it.
  task automatic acc(input bit ae, input bit aw, input logic [9:0] aad, input logic [31:0] awd,
                     input logic [3:0] abe, input bit bne, input bit bw, input logic [9:0] bad,
                     input logic [31:0] bwd, input logic [3:0] bbe, input bit [1:0] act);
    for (int d = 0; d < 2; d++) begin
      if (act[d]) begin
        bit ai, bi, awe, bwe;
        exp_t e;
        ai  = int'(aad) < dep[d];
        bi  = int'(bad) < dep[d];
        awe = ae && aw && ai;
        bwe = bne && bw && bi;
        if (ae && !aw) begin
          e.data = ai ? mdl[d][aad] : 32'h0;
          if (rdw[d] == 1 && ai && bwe && bad == aad) e.data = merge(e.data, bwd, bbe);
          e.due = cyc + lat[d];
          e.chk = known[d] || !ai;
          qr[d*2].push_back(e);
        end
        if (bne && !bw) begin
          e.data = bi ? mdl[d][bad] : 32'h0;
          if (rdw[d] == 1 && bi && awe && bad == aad) e.data = merge(e.data, awd, abe);
          e.due = cyc + lat[d];
          e.chk = known[d] || !bi;
          qr[d*2+1].push_back(e);
        end
        if ((ae && !ai) || (bne && !bi)) qf[d].push_back(cyc + lat[d]);
        if (awe && bwe && aad == bad) qf[2+d].push_back(cyc + 1);
        if (bwe) mdl[d][bad] = merge(mdl[d][bad], bwd, bbe);
        if (awe) mdl[d][aad] = merge(mdl[d][aad], awd, abe);
      end
    end
    a0.cs_n = !ae;  a0.wr = aw; a0.addr = aad; a0.wdata = awd; a0.be = abe;
    a1.cs_n = !ae;  a1.wr = aw; a1.addr = aad; a1.wdata = awd; a1.be = abe;
    b0.cs_n = !bne; b0.wr = bw; b0.addr = bad; b0.wdata = bwd; b0.be = bbe;
    b1.cs_n = !bne; b1.wr = bw; b1.addr = bad; b1.wdata = bwd; b1.be = bbe;
    @(posedge clk);
    #1;
    a0.cs_n = 1'b1; a1.cs_n = 1'b1; b0.cs_n = 1'b1; b1.cs_n = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) acc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11);
  endtask

  task automatic mon_port(input int idx, input logic rv, input logic [31:0] rd);
    exp_t e;
    bit   have;
    string nm;
    nm   = $sformatf("rd_dut%0d_port%s", idx / 2, (idx % 2) ? "B" : "A");
    have = qr[idx].size() > 0;
    if (have) e = qr[idx][0];
    if (rv) begin
      if (!have) begin
        check({nm, "_spurious_rvalid"}, 32'(rv), 32'h0);
      end else begin
        void'(qr[idx].pop_front());
        check({nm, "_latency_cycle"}, 32'(cyc), 32'(e.due));
        if (e.chk) check({nm, "_data"}, rd, e.data);
        last[idx]    = e.data;
        last_ok[idx] = e.chk;
      end
    end else begin
      if (have && e.due <= cyc) begin
        void'(qr[idx].pop_front());
        check({nm, "_missing_rvalid"}, 32'(rv), 32'h1);
      end
      if (last_ok[idx]) check({nm, "_hold"}, rd, last[idx]);
    end
  endtask

  task automatic mon_flag(input int idx, input logic act);
    bit exp;
    exp = 1'b0;
    if (qf[idx].size() > 0 && qf[idx][0] == cyc) begin
      exp = 1'b1;
      void'(qf[idx].pop_front());
    end
    if (exp || act) check($sformatf("flag_%s%0d", (idx < 2) ? "err" : "coll", idx % 2),
                          32'(act), 32'(exp));
  endtask

  always @(negedge clk) begin
    if (!nrst) begin
      for (int i = 0; i < 4; i++) begin
        last[i]    = 32'h0;
        last_ok[i] = 1'b1;
      end
    end else begin
      mon_port(0, a0.rvalid, a0.rdata);
      mon_port(1, b0.rvalid, b0.rdata);
      mon_port(2, a1.rvalid, a1.rdata);
      mon_port(3, b1.rvalid, b1.rdata);
      mon_flag(0, err0);
      mon_flag(1, err1);
      mon_flag(2, coll0);
      mon_flag(3, coll1);
    end
  end

  task automatic count_busy(input int exp0, input int exp1, input string nm);
    int c0, c1;
    c0 = 0;
    c1 = 0;
    for (int i = 0; i < 1100; i++) begin
      if (busy0) c0++;
      if (busy1) c1++;
      @(posedge clk);
      #1;
    end
    check({nm, "_busy_cycles_dut0"}, 32'(c0), 32'(exp0));
    check({nm, "_busy_cycles_dut1"}, 32'(c1), 32'(exp1));
  endtask

  function automatic logic [9:0] pick_addr();
    if ($urandom_range(0, 9) < 7) return 10'($urandom_range(0, 7));
    return 10'($urandom_range(995, 1023));
  endfunction

  initial begin
    int w;
    for (int d = 0; d < 2; d++) for (int i = 0; i < 1024; i++) mdl[d][i] = 32'h0;
    known[0] = 1'b0;
    known[1] = 1'b0;
    a0.cs_n = 1'b1; a1.cs_n = 1'b1; b0.cs_n = 1'b1; b1.cs_n = 1'b1;
    a0.wr = 0; a1.wr = 0; b0.wr = 0; b1.wr = 0;
    a0.addr = 0; a1.addr = 0; b0.addr = 0; b1.addr = 0;
    a0.wdata = 0; a1.wdata = 0; b0.wdata = 0; b1.wdata = 0;
    a0.be = 0; a1.be = 0; b0.be = 0; b1.be = 0;
    #2;
    check("reset_busy0", 32'(busy0), 32'h0);
    check("reset_rvalid_a0", 32'(a0.rvalid), 32'h0);
    check("reset_rdata_b1", b1.rdata, 32'h0);
    check("reset_err_coll", {30'h0, err0 | err1, coll0 | coll1}, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    nrst = 1'b1;

    // Automatic clear only on the CLR_ON_RST=1 instance, then an explicit clear on both.
    count_busy(1000, 0, "auto_clear");
    known[0] = 1'b1;
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    count_busy(1000, 1024, "req_clear");
    known[1] = 1'b1;

    acc(1, 0, 10'd0,    0, 0, 0, 0, 0, 0, 0, 2'b11);
    acc(1, 0, 10'd511,  0, 0, 0, 0, 0, 0, 0, 2'b11);
    acc(1, 0, 10'd999,  0, 0, 0, 0, 0, 0, 0, 2'b11);
    acc(1, 0, 10'd1023, 0, 0, 0, 0, 0, 0, 0, 2'b11);
    idle(2);

    acc(1, 1, 10'd20, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0, 2'b11);
    acc(1, 1, 10'd20, 32'h00001200, 4'b0010, 0, 0, 0, 0, 0, 2'b11);
    acc(1, 0, 10'd20, 0, 0, 0, 0, 0, 0, 0, 2'b11);
    acc(1, 1, 10'd20, 32'hFFFFFFFF, 4'h0, 0, 0, 0, 0, 0, 2'b11);
    acc(0, 0, 0, 0, 0, 1, 0, 10'd20, 0, 0, 2'b11);
    idle(2);

    acc(1, 1, 10'd5, 32'h11111111, 4'b0011, 1, 1, 10'd5, 32'h22222222, 4'hF, 2'b11);
    acc(1, 0, 10'd5, 0, 0, 1, 0, 10'd5, 0, 0, 2'b11);
    idle(2);

    acc(1, 1, 10'd7, 32'hAAAAAAAA, 4'hF, 0, 0, 0, 0, 0, 2'b11);
    acc(1, 1, 10'd7, 32'h55555555, 4'hF, 1, 0, 10'd7, 0, 0, 2'b11);
    acc(0, 0, 0, 0, 0, 1, 0, 10'd7, 0, 0, 2'b11);
    idle(2);

    acc(1, 1, 10'd1010, 32'h12345678, 4'hF, 1, 0, 10'd1000, 0, 0, 2'b11);
    acc(1, 0, 10'd1010, 0, 0, 1, 0, 10'd1010, 0, 0, 2'b11);
    idle(3);

    for (int i = 0; i < 400; i++) begin
      acc($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, pick_addr(), $urandom(),
          4'($urandom_range(0, 15)),
          $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, pick_addr(), $urandom(),
          4'($urandom_range(0, 15)), 2'b11);
    end
    idle(4);

    // Reset in the middle of a clear, then back-to-back reads on the instance that stays idle.
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    nrst = 1'b0;
    #1;
    check("midclear_reset_busy0", 32'(busy0), 32'h0);
    check("midclear_reset_busy1", 32'(busy1), 32'h0);
    @(posedge clk);
    #1;
    nrst = 1'b1;
    known[0] = 1'b0;
    known[1] = 1'b0;
    acc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
    check("after_release_busy0", 32'(busy0), 32'h1);
    check("after_release_busy1", 32'(busy1), 32'h0);
    for (int i = 0; i < 20; i++) acc(1, 0, 10'(i), 0, 0, 0, 0, 0, 0, 0, 2'b10);
    for (int i = 0; i < 4; i++) acc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
    w = 0;
    while (busy0 && w < 1100) begin
      @(posedge clk);
      #1;
      w++;
    end
    check("final_clear_done_busy0", 32'(busy0), 32'h0);
    idle(3);

    for (int i = 0; i < 4; i++) begin
      check($sformatf("leftover_reads_q%0d", i), 32'(qr[i].size()), 32'h0);
      check($sformatf("leftover_flags_q%0d", i), 32'(qf[i].size()), 32'h0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
